// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder
//
// Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-lookahead slice
// (gp4) for every nibble of the operand pair. It works from the LSB nibble to
// the MSB nibble, one nibble per clock. The carry between nibbles is held in a
// register. Requests and responses use valid/ready handshakes.
//
// Optional feature macro: CLA_SEQ_SUB_EN
//   When defined, the `sub` port exists and the block computes a-b. When
//   undefined, the block only adds and has no `sub` port.
//
// Parameters
//   WIDTH      operand width in bits; must be a multiple of 4 and at least 4
//
// Ports
//   clk        clock; all state updates happen on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  requester presents an operand pair
//   req_ready  block can accept a request (high only in IDLE)
//   a, b       operands, sampled on the request handshake
//   cin        carry-in, sampled on the request handshake
//   sub        subtract request (only with CLA_SEQ_SUB_EN)
//   resp_valid result is valid and held stable
//   resp_ready consumer accepts the result
//   sum        result
//   cout       carry out of bit WIDTH-1 (1 means "no borrow" when subtracting)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// gp4
//
// 4-bit carry-lookahead slice. It computes the internal carries c1..c3 and
// the group generate/propagate from the bit generates, the bit propagates and
// the slice carry-in.
//
// Ports
//   i_g  bit generates  (a & b)
//   i_p  bit propagates (a ^ b)
//   i_c  slice carry-in
//   o_c  {c3, c2, c1}
//   o_g  group generate
//   o_p  group propagate
// ---------------------------------------------------------------------------
module gp4 (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_c,
    output logic [2:0] o_c,
    output logic       o_g,
    output logic       o_p
);

    // Carries are flattened sum-of-products, so none of them ripples.
    always_comb begin
        o_c[0] = i_g[0] | (i_p[0] & i_c);
        o_c[1] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
        o_c[2] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
               | (i_p[2] & i_p[1] & i_p[0] & i_c);
        o_g    = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
               | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
        o_p    = &i_p;
    end

endmodule

module cla_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [WIDTH-1:0]  r_opA;
    logic [WIDTH-1:0]  r_opB;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic [WIDTH-1:0]  w_bIn;
    logic              w_cinIn;
    logic [3:0]        w_nibA;
    logic [3:0]        w_nibB;
    logic [3:0]        w_gin;
    logic [3:0]        w_pin;
    logic [2:0]        w_c;
    logic              w_gout;
    logic              w_pout;
    logic [3:0]        w_nibSum;
    logic              w_nextCarry;
    logic              w_lastNib;

    // Subtraction is a + ~b + 1, so it only changes what gets latched.
    // The nibble datapath is the same for add and subtract.
`ifdef CLA_SEQ_SUB_EN
    assign w_bIn   = sub ? ~b : b;
    assign w_cinIn = sub ? 1'b1 : cin;
`else
    assign w_bIn   = b;
    assign w_cinIn = cin;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RUN lasts exactly NIB cycles because the counter
    // stops at the last nibble instead of wrapping.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (req_valid)  w_nextState = RUN;
            RUN:     if (w_lastNib)  w_nextState = DONE;
            DONE:    if (resp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs are decoded only from the state register. This keeps
    // them glitch-free and independent of the inputs.
    always_comb begin
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == DONE);
    end

    // Select the operand nibbles that the counter points at.
    always_comb begin
        w_nibA = '0;
        w_nibB = '0;
        for (int i = 0; i < NIB; i++) begin
            if (r_cnt == CW'(i)) begin
                w_nibA = r_opA[4*i +: 4];
                w_nibB = r_opB[4*i +: 4];
            end
        end
    end

    assign w_gin       = w_nibA & w_nibB;
    assign w_pin       = w_nibA ^ w_nibB;
    assign w_nibSum    = w_pin ^ {w_c, r_carry};
    assign w_nextCarry = w_gout | (w_pout & r_carry);
    assign w_lastNib   = (r_cnt == CW'(NIB - 1));

    gp4 u_slice (
        .i_g (w_gin),
        .i_p (w_pin),
        .i_c (r_carry),
        .o_c (w_c),
        .o_g (w_gout),
        .o_p (w_pout)
    );

    // Datapath registers.
    // IDLE: the operands are captured on the handshake.
    // RUN:  one sum nibble is retired per cycle.
    // sum and cout are not touched outside RUN, so the last result stays
    //       visible in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_opA   <= a;
                        r_opB   <= w_bIn;
                        r_carry <= w_cinIn;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_sum[4*i +: 4] <= w_nibSum;
                        end
                    end
                    r_carry <= w_nextCarry;
                    if (w_lastNib) begin
                        r_cout <= w_nextCarry;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
